// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit
//  Purpose  : Multi-cycle multiply/divide unit for the E stage of a 5-stage
//             MIPS pipeline. Executes mult/multu/div/divu/mthi/mtlo and owns
//             the architectural HI/LO registers. The result is computed on the
//             accepting edge, held in pending registers, and committed to HI/LO
//             when the busy counter reaches zero.
//  Ports    : clk    - system clock, rising edge
//             reset  - synchronous active-high reset
//             Start  - E-stage instruction is an MDU arithmetic op
//             MDOp   - 0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 madd
//             A, B   - forwarded rs / rt operands
//             Busy   - registered, high while an operation is in flight
//             HI, LO - architectural HI/LO, read combinationally by mfhi/mflo
//  Options  : define MDU_MADD_EN to enable madd (MDOp 7); otherwise MDOp 7
//             behaves as MDOp 0.
//  Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;
`ifdef MDU_MADD_EN
    localparam logic [2:0] c_OP_MADD  = 3'd7;
`endif
    localparam logic [3:0] c_MULT_N   = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_N    = 4'(DIV_CYCLES);

    // Counter-implied state: IDLE when cnt_q == 0, RUN otherwise.
    logic [3:0]  cnt_q,  cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q,   hi_d;
    logic [31:0] lo_q,   lo_d;
    logic [31:0] phi_q,  phi_d;
    logic [31:0] plo_q,  plo_d;
    logic        pval_q, pval_d;   // pending result may be committed

    logic        w_madd_op;
    logic        w_mul_op;
    logic        w_div_op;
    logic        w_accept;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_quo_s;
    logic [31:0] w_rem_s;
    logic [63:0] w_result;

    // ------------------------------------------------------------------
    // Operation decode and datapath
    // ------------------------------------------------------------------
    always_comb begin
`ifdef MDU_MADD_EN
        w_madd_op = (MDOp == c_OP_MADD);
`else
        w_madd_op = 1'b0;
`endif
        w_mul_op = (MDOp == c_OP_MULT) || (MDOp == c_OP_MULTU) || w_madd_op;
        w_div_op = (MDOp == c_OP_DIV)  || (MDOp == c_OP_DIVU);
        w_accept = Start && (cnt_q == 4'd0) && (w_mul_op || w_div_op);
    end

    always_comb begin
        w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        w_prod_u = {32'd0, A} * {32'd0, B};

        // Signed divide runs on magnitudes through the same unsigned divider,
        // which also makes 0x80000000 / -1 wrap to 0x80000000 with no
        // overflow special case.
        w_a_mag = A[31] ? (32'd0 - A) : A;
        w_b_mag = B[31] ? (32'd0 - B) : B;
        w_dvd   = (MDOp == c_OP_DIV) ? w_a_mag : A;
        w_dvs   = (MDOp == c_OP_DIV) ? w_b_mag : B;
        // Divisor forced non-zero; a zero-divisor result is never committed.
        if (w_dvs == 32'd0) begin
            w_dvs = 32'd1;
        end
        w_quo   = w_dvd / w_dvs;
        w_rem   = w_dvd % w_dvs;
        w_quo_s = (A[31] ^ B[31]) ? (32'd0 - w_quo) : w_quo;
        w_rem_s = A[31] ? (32'd0 - w_rem) : w_rem;

        w_result = 64'd0;
        if (w_madd_op) begin
            w_result = {hi_q, lo_q} + w_prod_s;
        end else if (MDOp == c_OP_MULT) begin
            w_result = w_prod_s;
        end else if (MDOp == c_OP_MULTU) begin
            w_result = w_prod_u;
        end else if (MDOp == c_OP_DIV) begin
            w_result = {w_rem_s, w_quo_s};
        end else if (MDOp == c_OP_DIVU) begin
            w_result = {w_rem, w_quo};
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= 4'd0;
            busy_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            phi_q  <= 32'd0;
            plo_q  <= 32'd0;
            pval_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            phi_q  <= phi_d;
            plo_q  <= plo_d;
            pval_q <= pval_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        phi_d  = phi_q;
        plo_d  = plo_q;
        pval_d = pval_q;

        if (w_accept) begin
            cnt_d  = w_mul_op ? c_MULT_N : c_DIV_N;
            phi_d  = w_result[63:32];
            plo_d  = w_result[31:0];
            pval_d = !(w_div_op && (B == 32'd0));
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
            if ((cnt_q == 4'd1) && pval_q) begin
                hi_d = phi_q;
                lo_d = plo_q;
            end
        end else begin
            // mthi/mtlo only land while idle, so they never meet a commit.
            if (MDOp == c_OP_MTHI) begin
                hi_d = A;
            end
            if (MDOp == c_OP_MTLO) begin
                lo_d = A;
            end
        end

        busy_d = (cnt_d != 4'd0);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        Busy = busy_q;
        HI   = hi_q;
        LO   = lo_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_unit
//  Purpose  : Directed self-checking bench for md_unit. Expected HI/LO pairs
//             are queued when an operation is launched and compared when Busy
//             falls; Busy length and idle-time writes are checked directly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Start(Start),
        .MDOp (MDOp),
        .A    (A),
        .B    (B),
        .Busy (Busy),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Launch one op, count Busy cycles (bounded), then pop and compare HI/LO.
    // With interfere set, a mult Start and an mtlo are driven mid-operation.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n_exp, input bit interfere,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int   cnt;
        exp_t e;
        sb_q.push_back('{hi: exp_hi, lo: exp_lo});
        Start = 1'b1; MDOp = op; A = a; B = b;
        tick();
        Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
        cnt = 0;
        while (Busy === 1'b1 && cnt < 20) begin
            cnt++;
            if (interfere && cnt == 2) begin
                Start = 1'b1; MDOp = 3'd1; A = 32'd2; B = 32'd3;
            end else if (interfere && cnt == 3) begin
                Start = 1'b0; MDOp = 3'd6; A = 32'h55;
            end else begin
                if (interfere && cnt == 4) check({tag, "_lo_hold"}, LO, 32'h22);
                Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
            end
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(cnt), 32'(n_exp));
        e = sb_q.pop_front();
        check({tag, "_hi"}, HI, e.hi);
        check({tag, "_lo"}, LO, e.lo);
    endtask

    task automatic move_to(input logic [2:0] op, input logic st, input logic [31:0] a);
        Start = st; MDOp = op; A = a;
        tick();
        Start = 1'b0; MDOp = 3'd0; A = 32'd0;
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);

        // Multiplies
        run_op("mult_neg",  3'd1, 32'hFFFF_FFFE, 32'd3,        5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("mult_nn",   3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5, 1'b0, 32'h0000_0000, 32'h0000_000C);
        run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);

        // Divides
        run_op("divu_100_7", 3'd4, 32'd100,       32'd7,         10, 1'b0, 32'd2,         32'd14);
        run_op("div_m7_2",   3'd3, 32'hFFFF_FFF9, 32'd2,         10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf",    3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'h0000_0000, 32'h8000_0000);
        run_op("div_7_m2",   3'd3, 32'd7,         32'hFFFF_FFFE, 10, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD);

        // mthi with Start low, mtlo with Start high (treated as Start low)
        move_to(3'd5, 1'b0, 32'h11);
        check("mthi_hi", HI, 32'h11);
        check("mthi_busy", {31'd0, Busy}, 32'd0);
        move_to(3'd6, 1'b1, 32'h22);
        check("mtlo_lo", LO, 32'h22);
        check("mtlo_busy", {31'd0, Busy}, 32'd0);

        // Divide by zero keeps HI/LO
        run_op("div_by0", 3'd3, 32'd5, 32'd0, 10, 1'b0, 32'h11, 32'h22);

        // Start and mtlo during Busy are ignored
        run_op("divu_intf", 3'd4, 32'hFFFF_FFFF, 32'h10, 10, 1'b1, 32'h0000_000F, 32'h0FFF_FFFF);

        // Reset in cycle 3 of a mult aborts it
        Start = 1'b1; MDOp = 3'd1; A = 32'd7; B = 32'd9;
        tick();
        Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        repeat (8) tick();
        check("abort_late_busy", {31'd0, Busy}, 32'd0);
        check("abort_late_hi", HI, 32'd0);
        check("abort_late_lo", LO, 32'd0);

        // madd from HI=0, LO=0xFFFFFFFF
        move_to(3'd5, 1'b0, 32'h0);
        move_to(3'd6, 1'b0, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        run_op("madd", 3'd7, 32'd1, 32'd1, 5, 1'b0, 32'h1, 32'h0);
`else
        run_op("madd_off", 3'd7, 32'd1, 32'd1, 0, 1'b0, 32'h0, 32'hFFFF_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
